store_buffer: RTL

- Post-execute stage fed directly by the store reservation stations' address/data/valid/RB_index outputs.
- Holds completed-but-uncommitted stores until the reorder buffer commits them.
- Drains committed stores to data memory strictly in commit order, one at a time, over a req/ack handshake.
- On flush, speculative (uncommitted) stores are discarded; committed stores are preserved.

---
 rtl/store_buffer_pkg.sv | 22 ++
 rtl/store_commit_fifo.sv | 59 +++++
 rtl/store_buffer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
//==============================================================================
// Module : store_buffer_pkg
// Brief  : Shared widths, null ROB index and drain FSM encoding for the store buffer
// Rev    : 1.0
//==============================================================================
`default_nettype none

package store_buffer_pkg;

    localparam int SB_WORD_SIZE = 32;
    localparam int SB_RB_INDEX  = 4;

    localparam logic [SB_RB_INDEX-1:0] SB_NULL_RB = '0;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } drain_state_e;

endpackage

`default_nettype wire

// File: rtl/store_commit_fifo.sv
//==============================================================================
// Module : store_commit_fifo
// Brief  : Slot-index FIFO recording the order in which stores were committed
// Rev    : 1.0
//==============================================================================
`default_nettype none

module store_commit_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [PTR_W-1:0] push_idx,
    input  logic             pop,
    output logic [PTR_W-1:0] head,
    output logic             empty
);

    logic [PTR_W-1:0] slots_q [DEPTH];
    logic [PTR_W-1:0] slots_d [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

    // Extra pointer bit separates full from empty; occupancy never exceeds DEPTH.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = slots_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        slots_d  = slots_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            slots_d[wr_ptr_q[PTR_W-1:0]] = push_idx;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            slots_q  <= slots_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
//==============================================================================
// Module : store_buffer
// Brief  : Holds completed stores until ROB commit, drains them in commit order
// Rev    : 1.0
//==============================================================================
`default_nettype none

module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int WORD_SIZE = SB_WORD_SIZE,
    parameter int RB_INDEX  = SB_RB_INDEX,
    parameter int DEPTH     = 4,
    parameter int PTR_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 st_valid,
    input  logic [WORD_SIZE-1:0] st_addr,
    input  logic [WORD_SIZE-1:0] st_data,
    input  logic [RB_INDEX-1:0]  st_rb_index,
    output logic                 full,
    input  logic                 commit_valid,
    input  logic [RB_INDEX-1:0]  commit_rb_index,
    input  logic                 flush,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_ack,
    output logic                 empty,
    output logic [PTR_W:0]       count,
    output logic                 overflow,
    output logic                 commit_miss
);

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     committed_q, committed_d;
    logic [WORD_SIZE-1:0] addr_q [DEPTH];
    logic [WORD_SIZE-1:0] addr_d [DEPTH];
    logic [WORD_SIZE-1:0] data_q [DEPTH];
    logic [WORD_SIZE-1:0] data_d [DEPTH];
    logic [RB_INDEX-1:0]  rb_q   [DEPTH];
    logic [RB_INDEX-1:0]  rb_d   [DEPTH];

    drain_state_e         state_q, state_d;
    logic                 mem_we_q, mem_we_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 overflow_q, overflow_d;
    logic                 commit_miss_q, commit_miss_d;

    logic [PTR_W:0]       count_w;
    logic                 full_w;
    logic                 free_found;
    logic [PTR_W-1:0]     free_idx;
    logic                 hit_found;
    logic [PTR_W-1:0]     hit_idx;
    logic                 alloc_en;
    logic                 alloc_commit;
    logic                 fifo_push;
    logic [PTR_W-1:0]     fifo_push_idx;
    logic                 fifo_pop;
    logic [PTR_W-1:0]     fifo_head;
    logic                 fifo_empty;

    always_comb begin
        count_w    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        hit_found  = 1'b0;
        hit_idx    = '0;
        // Descending scan so the lowest-index free slot is the one that sticks.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            count_w = count_w + (PTR_W + 1)'(valid_q[i]);
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = PTR_W'(i);
            end
            if (valid_q[i] && !committed_q[i] && (rb_q[i] == commit_rb_index)) begin
                hit_found = 1'b1;
                hit_idx   = PTR_W'(i);
            end
        end
    end

    assign full_w        = (count_w == (PTR_W + 1)'(DEPTH));
    assign alloc_en      = st_valid && free_found && !flush;
    assign alloc_commit  = alloc_en && commit_valid && !hit_found && (st_rb_index == commit_rb_index);
    assign fifo_push     = commit_valid && (hit_found || alloc_commit);
    assign fifo_push_idx = hit_found ? hit_idx : free_idx;

    store_commit_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_commit_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_idx (fifo_push_idx),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .empty    (fifo_empty)
    );

    always_comb begin
        valid_d       = valid_q;
        committed_d   = committed_q;
        addr_d        = addr_q;
        data_d        = data_q;
        rb_d          = rb_q;
        state_d       = state_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        fifo_pop      = 1'b0;
        overflow_d    = overflow_q | (st_valid && full_w && !flush);
        commit_miss_d = commit_miss_q | (commit_valid && !fifo_push);

        if (alloc_en) begin
            valid_d[free_idx]     = 1'b1;
            committed_d[free_idx] = alloc_commit;
            addr_d[free_idx]      = st_addr;
            data_d[free_idx]      = st_data;
            rb_d[free_idx]        = st_rb_index;
        end
        if (commit_valid && hit_found) begin
            committed_d[hit_idx] = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q[fifo_head];
                    mem_wdata_d = data_q[fifo_head];
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    fifo_pop               = 1'b1;
                    valid_d[fifo_head]     = 1'b0;
                    committed_d[fifo_head] = 1'b0;
                    mem_we_d               = 1'b0;
                    state_d                = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Commit is folded in above, so a same-cycle commit keeps its entry alive.
        if (flush) begin
            valid_d = valid_d & committed_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= '0;
            committed_q   <= '0;
            state_q       <= S_IDLE;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            overflow_q    <= 1'b0;
            commit_miss_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                rb_q[i]   <= RB_INDEX'(SB_NULL_RB);
            end
        end else begin
            valid_q       <= valid_d;
            committed_q   <= committed_d;
            state_q       <= state_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            overflow_q    <= overflow_d;
            commit_miss_q <= commit_miss_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            rb_q          <= rb_d;
        end
    end

    assign full        = full_w;
    assign empty       = (count_w == '0);
    assign count       = count_w;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign overflow    = overflow_q;
    assign commit_miss = commit_miss_q;

endmodule

`default_nettype wire
